timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
- Key-driven sequencing controller for the 60 s countdown timer datapath.
- Converts raw push-button inputs into clean press events, owns the run/pause/set/alarm mode, and supplies the preset digits plus load/en/pause controls to the timer core.
- Drives the expiry LED.
- Sits between the board keys and the timer core, in the clk_50M domain, upstream of the divider-clocked counter logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a synchronized key must be stable before its new level is accepted (20 ms at 50 MHz).
- ALARM_CYCLES, 150000000: duration of the ALARM state, in cycles (3 s).
- BLINK_HALF, 12500000: LED half-period during ALARM, in cycles (2 Hz blink).
- PRESET_TEN, 6: tens digit loaded at reset and on key_reset.
- PRESET_ONE, 0: ones digit loaded at reset and on key_reset.

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_start  in  1  raw start button, active-low, asynchronous.
- key_pause  in  1  raw pause/resume button, active-low, asynchronous.
- key_reset  in  1  raw reset-to-preset button, active-low, asynchronous.
- key_set_ten  in  1  raw tens-digit increment button, active-low.
- key_set_one  in  1  raw ones-digit increment button, active-low.
- cnt_zero  in  1  level from timer core; high when count equals 00.0. Synchronous to clk_50M.
- ten  out  4  preset tens digit, BCD 0..6.
- one  out  4  preset ones digit, BCD 0..9.
- load  out  1  one-cycle pulse; the timer core copies ten/one into its count.
- en  out  1  timer enable.
- pause  out  1  timer hold.
- led  out  1  expiry indicator.
- state  out  3  current FSM state, for debug and display.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE
  - ten=PRESET_TEN, one=PRESET_ONE
  - load=0, en=0, pause=0, led=0
  - all debounce counters 0, all debounced levels 1 (released).
- Key path, per key:
  - 2-FF synchronizer, then debounce counter.
  - The counter resets whenever the synchronized level equals the accepted level; when it reaches DEBOUNCE_CYCLES-1 the accepted level flips.
  - A 1->0 flip of the accepted level produces a one-cycle press event. Releases produce no event.
  - Latency: press event is high on cycle 2+DEBOUNCE_CYCLES after a clean falling edge. A glitch shorter than DEBOUNCE_CYCLES produces no event.
  - FSM reacts on the edge after the event.
- Event priority in the same cycle: reset > cnt_zero (RUN only) > start > pause > set_ten > set_one. Only the highest-priority event acts; lower ones are dropped.
- IDLE (en=0, pause=0):
  - start with {ten,one}!=00: load=1 for one cycle, go to RUN.
  - start with {ten,one}==00: ignored.
  - set_ten or set_one: apply the increment and go to SET.
- SET (en=0):
  - set_ten: ten=(ten==6)?0:ten+1. If the new ten is 6, force one=0.
  - set_one: if ten==6, one stays 0; else one=(one==9)?0:one+1.
  - start: same rule as IDLE.
  - reset: restore presets, go to IDLE.
- RUN (en=1, pause=0):
  - cnt_zero=1: go to ALARM.
  - pause: go to PAUSED.
  - reset: restore presets, pulse load, go to IDLE.
  - start and set keys: ignored.
- PAUSED (en=1, pause=1):
  - pause or start: go to RUN.
  - reset: as in RUN.
  - cnt_zero: ignored, since the count is frozen.
- ALARM (en=0, pause=0):
  - Alarm counter runs from 0. led toggles every BLINK_HALF cycles, starting at 1 on entry.
  - Counter reaching ALARM_CYCLES-1, or any press event: led=0, go to IDLE. ten/one keep their current values.
- load is asserted only on the transitions listed above; it is never high for two consecutive cycles.
- Reset asserted mid-operation: immediate return to reset values regardless of state, including mid-debounce and mid-alarm.
- state encoding: IDLE=0, SET=1, RUN=2, PAUSED=3, ALARM=4. Codes 5..7 are unreachable; if entered, recover to IDLE on the next edge.

Decomposition:
- Shared package timer_pkg holds:
  - state enum and its encodings
  - PRESET_TEN/PRESET_ONE defaults
  - BCD limits (TEN_MAX=6, ONE_MAX=9)
- One sub-module, key_debounce (synchronizer + counter + press-event output, parameter DEBOUNCE_CYCLES), instantiated five times.
- FSM, digit editing and alarm blink live in timer_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, ALARM_CYCLES=40, BLINK_HALF=5):
- Reset release, key_start held low 6 cycles -> load high exactly 1 cycle at cycle 7; state IDLE->RUN; en=1; ten=6, one=0.
- key_pause low pulse of 3 cycles during RUN -> no event, state stays RUN. Held low 6 cycles -> PAUSED, pause=1. Pressed again -> RUN, pause=0.
- From IDLE, key_set_ten pressed 2 times -> ten sequence 6->0->1, state SET. key_set_one pressed 10 times -> one wraps 0..9->0. Then ten advanced to 6 -> one forced to 0.
- In RUN, raise cnt_zero -> ALARM next edge, led=1. led toggles every 5 cycles. IDLE after 40 cycles with led=0. Repeat with a key press at cycle 12 -> IDLE immediately.
- In RUN, cnt_zero and a pause event in the same cycle -> ALARM, not PAUSED.
- Drive rst_n low mid-PAUSED and mid-ALARM -> all outputs at reset values asynchronously; ten=6, one=0, state=0. Start with ten=0, one=0 in SET -> no load, state stays SET.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, preset defaults and BCD limits for the timer controller.
package timer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SET    = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_ALARM  = 3'd4
    } state_t;

    localparam logic [3:0] PRESET_TEN_DEF = 4'd6;
    localparam logic [3:0] PRESET_ONE_DEF = 4'd0;
    localparam logic [3:0] TEN_MAX        = 4'd6;
    localparam logic [3:0] ONE_MAX        = 4'd9;

    // Bit positions of the per-key press events.
    localparam int EV_START   = 0;
    localparam int EV_PAUSE   = 1;
    localparam int EV_RESET   = 2;
    localparam int EV_SET_TEN = 3;
    localparam int EV_SET_ONE = 4;

    function automatic logic [3:0] inc_wrap(input logic [3:0] v, input logic [3:0] max);
        return (v == max) ? 4'd0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer plus stability counter for one active-low key.
// Emits a one-cycle press event when the accepted level falls; releases are silent.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          w_flip;

    assign w_flip  = (r_sync[1] != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign o_press = r_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key};
            r_cnt   <= (r_sync[1] == r_level || w_flip) ? '0 : r_cnt + CW'(1);
            r_level <= w_flip ? ~r_level : r_level;
            r_press <= w_flip && r_level;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: key-driven run/pause/set/alarm sequencer for the 60 s countdown timer.
// Debounces the board keys, edits the preset digits, drives load/en/pause and blinks the LED.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         ALARM_CYCLES    = 150000000,
    parameter int         BLINK_HALF      = 12500000,
    parameter logic [3:0] PRESET_TEN      = PRESET_TEN_DEF,
    parameter logic [3:0] PRESET_ONE      = PRESET_ONE_DEF
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_reset,
    input  logic       key_set_ten,
    input  logic       key_set_one,
    input  logic       cnt_zero,
    output logic [3:0] ten,
    output logic [3:0] one,
    output logic       load,
    output logic       en,
    output logic       pause,
    output logic       led,
    output logic [2:0] state
);
    localparam int AW = $clog2(ALARM_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    state_t        r_state, w_state;
    logic [3:0]    r_ten, r_one, w_ten, w_one;
    logic          r_load, w_load, r_led, w_led;
    logic [AW-1:0] r_acnt, w_acnt;
    logic [BW-1:0] r_bcnt, w_bcnt;
    logic [4:0]    w_raw, w_ev;
    logic          w_any, w_can_start, w_blink_wrap;

    assign w_raw = {key_set_one, key_set_ten, key_reset, key_pause, key_start};

    genvar k;
    for (k = 0; k < 5; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
            .i_clk  (clk_50M),
            .i_rst_n(rst_n),
            .i_key  (w_raw[k]),
            .o_press(w_ev[k])
        );
    end

    assign w_any        = |w_ev;
    // A start right after a load would make load high two cycles running.
    assign w_can_start  = ({r_ten, r_one} != 8'h00) && !r_load;
    assign w_blink_wrap = (r_bcnt == BW'(BLINK_HALF - 1));

    always_comb begin
        w_state = r_state;
        w_ten   = r_ten;
        w_one   = r_one;
        w_load  = 1'b0;
        w_led   = r_led;
        w_acnt  = r_acnt;
        w_bcnt  = r_bcnt;
        case (r_state)
            S_IDLE, S_SET: begin
                if (w_ev[EV_RESET]) begin
                    w_state = S_IDLE;
                    w_ten   = PRESET_TEN;
                    w_one   = PRESET_ONE;
                end else if (w_ev[EV_START]) begin
                    w_state = w_can_start ? S_RUN : r_state;
                    w_load  = w_can_start;
                end else if (!w_ev[EV_PAUSE] && w_ev[EV_SET_TEN]) begin
                    w_state = S_SET;
                    w_ten   = inc_wrap(r_ten, TEN_MAX);
                    w_one   = (w_ten == TEN_MAX) ? 4'd0 : r_one;
                end else if (!w_ev[EV_PAUSE] && w_ev[EV_SET_ONE]) begin
                    w_state = S_SET;
                    w_one   = (r_ten == TEN_MAX) ? 4'd0 : inc_wrap(r_one, ONE_MAX);
                end
            end
            S_RUN, S_PAUSED: begin
                if (w_ev[EV_RESET]) begin
                    w_state = S_IDLE;
                    w_ten   = PRESET_TEN;
                    w_one   = PRESET_ONE;
                    w_load  = !r_load;
                end else if (r_state == S_RUN && cnt_zero) begin
                    w_state = S_ALARM;
                    w_led   = 1'b1;
                    w_acnt  = '0;
                    w_bcnt  = '0;
                end else if (r_state == S_RUN) begin
                    w_state = w_ev[EV_PAUSE] ? S_PAUSED : S_RUN;
                end else begin
                    w_state = (w_ev[EV_START] || w_ev[EV_PAUSE]) ? S_RUN : S_PAUSED;
                end
            end
            S_ALARM: begin
                if (w_any || r_acnt == AW'(ALARM_CYCLES - 1)) begin
                    w_state = S_IDLE;
                    w_led   = 1'b0;
                end else begin
                    w_acnt = r_acnt + AW'(1);
                    w_bcnt = w_blink_wrap ? '0 : r_bcnt + BW'(1);
                    w_led  = w_blink_wrap ? ~r_led : r_led;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_led   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ten   <= PRESET_TEN;
            r_one   <= PRESET_ONE;
            r_load  <= 1'b0;
            r_led   <= 1'b0;
            r_acnt  <= '0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state;
            r_ten   <= w_ten;
            r_one   <= w_one;
            r_load  <= w_load;
            r_led   <= w_led;
            r_acnt  <= w_acnt;
            r_bcnt  <= w_bcnt;
        end
    end

    assign ten   = r_ten;
    assign one   = r_one;
    assign load  = r_load;
    assign led   = r_led;
    assign state = r_state;
    assign en    = (r_state == S_RUN) || (r_state == S_PAUSED);
    assign pause = (r_state == S_PAUSED);

endmodule
